// File: rtl/rx_cmd_decoder_if.sv
// Handshake bundle between the rx command decoder and its FIFO, buffer,
// readout and compute neighbours.
interface rx_cmd_decoder_if #(
    parameter int FIFO_DATA_WIDTH  = 8,
    parameter int BUFFER_WORD_SIZE = 16,
    parameter int ADDRESS_SIZE     = 10
);
    logic                        fifo_empty;
    logic                        fifo_re;
    logic [FIFO_DATA_WIDTH-1:0]  fifo_data;
    logic                        buf_we;
    logic [ADDRESS_SIZE-1:0]     buf_addr;
    logic [BUFFER_WORD_SIZE-1:0] buf_wdata;
    logic                        rd_start;
    logic [ADDRESS_SIZE-1:0]     rd_addr;
    logic [7:0]                  rd_len;
    logic                        rd_done;
    logic                        compute_start;
    logic                        relu_en;
    logic                        compute_done;
    logic                        busy;
    logic                        cmd_err;

    modport master (
        input  fifo_empty, fifo_data, rd_done, compute_done,
        output fifo_re, buf_we, buf_addr, buf_wdata,
        output rd_start, rd_addr, rd_len,
        output compute_start, relu_en, busy, cmd_err
    );

    modport slave (
        output fifo_empty, fifo_data, rd_done, compute_done,
        input  fifo_re, buf_we, buf_addr, buf_wdata,
        input  rd_start, rd_addr, rd_len,
        input  compute_start, relu_en, busy, cmd_err
    );
endinterface

// File: rtl/rx_cmd_decoder.sv
// Byte-stream command decoder: pulls packets from the rx FIFO and turns
// them into buffer writes, readout requests and compute starts.
module rx_cmd_decoder #(
    parameter int FIFO_DATA_WIDTH  = 8,
    parameter int BUFFER_WORD_SIZE = 16,
    parameter int ADDRESS_SIZE     = 10
) (
    input  logic           clk,
    input  logic           rst,
    rx_cmd_decoder_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, LEN,
        DATA_HI, DATA_LO, RD_WAIT, CMP_WAIT
    } state_e;

    state_e state_q, state_d;
    logic re_q, re_d;
    logic pend_q, pend_d;
    logic is_rd_q, is_rd_d;
    logic [7:0] addr_hi_q, addr_hi_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [7:0] len_q, len_d;
    logic [FIFO_DATA_WIDTH-1:0] hi_q, hi_d;
    logic we_q, we_d;
    logic [ADDRESS_SIZE-1:0] baddr_q, baddr_d;
    logic [BUFFER_WORD_SIZE-1:0] wdata_q, wdata_d;
    logic rs_q, rs_d;
    logic [ADDRESS_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [7:0] rd_len_q, rd_len_d;
    logic cs_q, cs_d;
    logic relu_q, relu_d;
    logic err_q, err_d;
    logic busy_q, busy_d;
    logic [7:0] b;
    logic readable;

    assign b = bus.fifo_data[7:0];

    always_comb begin
        state_d   = state_q;
        is_rd_d   = is_rd_q;
        addr_hi_d = addr_hi_q;
        addr_d    = addr_q;
        len_d     = len_q;
        hi_d      = hi_q;
        baddr_d   = baddr_q;
        wdata_d   = wdata_q;
        rd_addr_d = rd_addr_q;
        rd_len_d  = rd_len_q;
        relu_d    = relu_q;
        we_d      = 1'b0;
        rs_d      = 1'b0;
        cs_d      = 1'b0;
        err_d     = 1'b0;
        // a byte fetched last cycle is on fifo_data now
        pend_d    = re_q;
        unique case (state_q)
            IDLE: if (pend_q) begin
                if (b == 8'h01 || b == 8'h02) begin
                    is_rd_d = b[1];
                    state_d = ADDR_HI;
                end else if (b[6:0] == 7'h03) begin
                    cs_d    = 1'b1;
                    relu_d  = b[7];
                    state_d = CMP_WAIT;
                end else begin
                    err_d = 1'b1;
                end
            end
            ADDR_HI: if (pend_q) begin
                addr_hi_d = b;
                state_d   = ADDR_LO;
            end
            ADDR_LO: if (pend_q) begin
                addr_d  = ADDRESS_SIZE'({addr_hi_q, b});
                state_d = LEN;
            end
            LEN: if (pend_q) begin
                len_d = b;
                if (is_rd_q) begin
                    rs_d      = 1'b1;
                    rd_addr_d = addr_q;
                    rd_len_d  = b;
                    state_d   = RD_WAIT;
                end else begin
                    state_d = (b == 8'h00) ? IDLE : DATA_HI;
                end
            end
            DATA_HI: if (pend_q) begin
                hi_d    = bus.fifo_data;
                state_d = DATA_LO;
            end
            DATA_LO: if (pend_q) begin
                we_d    = 1'b1;
                baddr_d = addr_q;
                wdata_d = BUFFER_WORD_SIZE'({hi_q, bus.fifo_data});
                addr_d  = addr_q + ADDRESS_SIZE'(1);
                len_d   = len_q - 8'd1;
                state_d = (len_q == 8'd1) ? IDLE : DATA_HI;
            end
            RD_WAIT: if (bus.rd_done) begin
                state_d = IDLE;
            end
            CMP_WAIT: if (bus.compute_done) begin
                relu_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        readable = (state_q != RD_WAIT) && (state_q != CMP_WAIT);
        re_d   = readable && !bus.fifo_empty && !re_q && !pend_q;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            re_q      <= 1'b0;
            pend_q    <= 1'b0;
            is_rd_q   <= 1'b0;
            addr_hi_q <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            hi_q      <= '0;
            we_q      <= 1'b0;
            baddr_q   <= '0;
            wdata_q   <= '0;
            rs_q      <= 1'b0;
            rd_addr_q <= '0;
            rd_len_q  <= '0;
            cs_q      <= 1'b0;
            relu_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            re_q      <= re_d;
            pend_q    <= pend_d;
            is_rd_q   <= is_rd_d;
            addr_hi_q <= addr_hi_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            hi_q      <= hi_d;
            we_q      <= we_d;
            baddr_q   <= baddr_d;
            wdata_q   <= wdata_d;
            rs_q      <= rs_d;
            rd_addr_q <= rd_addr_d;
            rd_len_q  <= rd_len_d;
            cs_q      <= cs_d;
            relu_q    <= relu_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.fifo_re       = re_q;
    assign bus.buf_we        = we_q;
    assign bus.buf_addr      = baddr_q;
    assign bus.buf_wdata     = wdata_q;
    assign bus.rd_start      = rs_q;
    assign bus.rd_addr       = rd_addr_q;
    assign bus.rd_len        = rd_len_q;
    assign bus.compute_start = cs_q;
    assign bus.relu_en       = relu_q;
    assign bus.busy          = busy_q;
    assign bus.cmd_err       = err_q;
endmodule

// File: doc/rx_cmd_decoder.md
RX_CMD_DECODER -- requirements
Module: rx_cmd_decoder

Interface
REQ-001 SHALL have parameter FIFO_DATA_WIDTH, default 8: byte width of the rx FIFO read port.
REQ-002 SHALL have parameter BUFFER_WORD_SIZE, default 16: unified buffer word width, equal to 2*FIFO_DATA_WIDTH.
REQ-003 SHALL have parameter ADDRESS_SIZE, default 10: unified buffer address width.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous and active-low (0 = reset).
REQ-006 SHALL have port fifo_empty  input  1: rx FIFO empty flag.
REQ-007 SHALL have port fifo_re  output  1: rx FIFO read strobe.
REQ-008 SHALL have port fifo_data  input  FIFO_DATA_WIDTH: rx FIFO read data, valid the cycle after fifo_re.
REQ-009 SHALL have port buf_we  output  1: unified buffer write strobe.
REQ-010 SHALL have port buf_addr  output  ADDRESS_SIZE: buffer write address.
REQ-011 SHALL have port buf_wdata  output  BUFFER_WORD_SIZE: buffer write data.
REQ-012 SHALL have port rd_start  output  1: one-cycle pulse requesting a buffer-to-tx readout.
REQ-013 SHALL have port rd_addr  output  ADDRESS_SIZE: readout start address, held from rd_start until rd_done.
REQ-014 SHALL have port rd_len  output  8: readout word count, held from rd_start until rd_done.
REQ-015 SHALL have port rd_done  input  1: readout complete pulse.
REQ-016 SHALL have port compute_start  output  1: one-cycle pulse starting the MAC array.
REQ-017 SHALL have port relu_en  output  1: leaky-ReLU enable, held from compute_start until compute_done.
REQ-018 SHALL have port compute_done  input  1: compute complete pulse.
REQ-019 SHALL have port busy  output  1: high whenever the state is not IDLE.
REQ-020 SHALL have port cmd_err  output  1: one-cycle pulse on an unknown opcode.

Function
REQ-021 SHALL assert fifo_re only when fifo_empty=0 and no fetched byte is outstanding; at most one byte in flight.
REQ-022 SHALL run states IDLE, ADDR_HI, ADDR_LO, LEN, DATA_HI, DATA_LO, RD_WAIT, CMP_WAIT; each byte-consuming state advances on the cycle its byte is valid.
REQ-023 SHALL decode the opcode byte in IDLE: 0x01 WRITE, 0x02 READ, 0x03 COMPUTE without ReLU, 0x83 COMPUTE with ReLU; any other value pulses cmd_err, discards the byte, and stays in IDLE.
REQ-024 SHALL for WRITE/READ take address = {addr_hi[1:0], addr_lo} (addr_hi[7:2] ignored), then len byte.
REQ-025 SHALL for WRITE with len=N>0 collect N words, each high byte then low byte; buf_we pulses one cycle on low-byte arrival with buf_wdata={hi,lo} and buf_addr = current address.
REQ-026 SHALL increment the write address after each word, wrapping 1023 -> 0.
REQ-027 SHALL for WRITE with len=0 return to IDLE after the len byte with no buf_we.
REQ-028 SHALL for READ pulse rd_start the cycle after the len byte is valid (including len=0), enter RD_WAIT, and return to IDLE on rd_done.
REQ-029 SHALL for COMPUTE pulse compute_start the cycle after the opcode is valid, drive relu_en = opcode[7], enter CMP_WAIT, and return to IDLE on compute_done.
REQ-030 SHALL not assert fifo_re in RD_WAIT or CMP_WAIT; bytes stay queued in the FIFO.
REQ-031 SHALL ignore rd_done/compute_done outside their wait states.
REQ-032 SHALL stall indefinitely on fifo_empty mid-packet, with no timeout and outputs held.

Reset
REQ-033 SHALL on rst=0 immediately force IDLE, clear the outstanding-byte flag, and drive fifo_re, buf_we, rd_start, compute_start, cmd_err, busy, relu_en = 0 and buf_addr, buf_wdata, rd_addr, rd_len = 0.
REQ-034 SHALL on reset mid-packet discard the partial packet; the next byte after release is treated as an opcode.

Verification
REQ-035 SHALL pass: bytes 01 00 05 02 12 34 AB CD -> buf_we at addr 5 data 0x1234, then addr 6 data 0xABCD; busy falls after the last word.
REQ-036 SHALL pass: 01 03 FF 02 then 4 data bytes -> writes at addr 1023 then 0 (wrap).
REQ-037 SHALL pass: 02 01 10 04 -> rd_start one pulse, rd_addr=0x110, rd_len=4; next opcode unread until rd_done.
REQ-038 SHALL pass: 83 -> compute_start pulse, relu_en=1 held until compute_done, then IDLE.
REQ-039 SHALL pass: 7F then 03 -> cmd_err pulse for 0x7F, then compute_start with relu_en=0.
REQ-040 SHALL pass: rst=0 asserted after 01 00 05 02 12 -> outputs zero asynchronously; after release, byte 03 starts a compute.
